// File: rtl/bus_arbiter4_if.sv
// Bus arbiter handshake bundle. "master" is the requester/memory side
// of the arbiter; "slave" is the arbiter itself.
interface bus_arbiter4_if;
    logic [3:0] req;
    logic       mem_ack;
    logic [3:0] grant;
    logic [1:0] select;
    logic       mem_req;
    logic [3:0] done;
    logic [3:0] timeout;
    logic       busy;

    modport master (
        output req, mem_ack,
        input  grant, select, mem_req, done, timeout, busy
    );

    modport slave (
        input  req, mem_ack,
        output grant, select, mem_req, done, timeout, busy
    );
endinterface

// File: rtl/bus_arbiter4.sv
// Four-master round-robin arbiter in front of the address/data bus mux.
// It grants one master at a time and runs the single-beat req/ack
// handshake toward memory. A watchdog ends any transaction that memory
// never acknowledges.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no owner; pick the next requester starting at ptr
// ST_BUSY    | grant held, mem_req high, waiting for ack or watchdog
// ST_RELEASE | one dead cycle with grant and mem_req low before next grant
module bus_arbiter4 #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    bus_arbiter4_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // TIMEOUT_CYCLES of 0 turns the watchdog off. In that case the
    // compare value is never used.
    localparam bit         TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] select_q, select_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] done_q, done_d;
    logic [3:0] timeout_q, timeout_d;
    logic [7:0] cnt_q, cnt_d;

    logic [1:0] pick;
    logic       found;
    logic [1:0] idx;

    // Round-robin search: the first requester at or after ptr, mod 4.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && bus.req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state logic and registered outputs.
    // done and timeout are pulses, so they default to zero.
    // select is kept outside BUSY so the mux output does not move.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        select_d  = select_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        done_d    = 4'd0;
        timeout_d = 4'd0;
        unique case (state_q)
            ST_IDLE: begin
                if (found) begin
                    select_d = pick;
                    grant_d  = 4'b0001 << pick;
                    cnt_d    = 8'd0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ack) begin
                    done_d  = 4'b0001 << select_q;
                    ptr_d   = select_q + 2'd1;
                    grant_d = 4'd0;
                    state_d = ST_RELEASE;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    timeout_d = 4'b0001 << select_q;
                    ptr_d     = select_q + 2'd1;
                    grant_d   = 4'd0;
                    state_d   = ST_RELEASE;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. An async reset clears the grant at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            select_q  <= 2'd0;
            grant_q   <= 4'd0;
            done_q    <= 4'd0;
            timeout_q <= 4'd0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            select_q  <= select_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.select  = select_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.mem_req = (state_q == ST_BUSY);
    assign bus.busy    = (state_q == ST_BUSY) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4 with the watchdog set to 4 cycles.
// Each table row holds the inputs applied before a rising edge and the
// outputs expected just after that edge.
module tb_bus_arbiter4;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       mreq;
        logic [3:0] done;
        logic [3:0] tout;
        logic       busy;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    bus_arbiter4_if bus_if ();

    bus_arbiter4 #(.TIMEOUT_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic a, input logic [3:0] g,
                       input logic [1:0] s, input logic m, input logic [3:0] d,
                       input logic [3:0] t, input logic b);
        vec_t v;
        v.req = r; v.ack = a; v.grant = g; v.sel = s;
        v.mreq = m; v.done = d; v.tout = t; v.busy = b;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        //   req      ack  grant    sel  mreq done     tout     busy
        // Round robin with all four masters requesting.
        add(4'b1111, 0, 4'b0001, 0, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 1);
        add(4'b1111, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b0000, 1, 0, 4'b0010, 4'b0000, 1);
        add(4'b1111, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 0, 4'b0100, 2, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b0000, 2, 0, 4'b0100, 4'b0000, 1);
        add(4'b1111, 0, 4'b0000, 2, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 0, 4'b1000, 3, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b0000, 3, 0, 4'b1000, 4'b0000, 1);
        add(4'b1111, 0, 4'b0000, 3, 0, 4'b0000, 4'b0000, 0);
        add(4'b1111, 0, 4'b0001, 0, 1, 4'b0000, 4'b0000, 1);
        add(4'b1111, 1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 1);
        // Spurious ack in RELEASE, then in IDLE.
        add(4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        add(4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        // Master 1 is served. Its req drops mid-BUSY but it still completes.
        add(4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000, 1);
        add(4'b1001, 1, 4'b0000, 1, 0, 4'b0010, 4'b0000, 1);
        add(4'b1001, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        // Pointer skip: master 3 wins over master 0.
        add(4'b1001, 0, 4'b1000, 3, 1, 4'b0000, 4'b0000, 1);
        add(4'b1001, 1, 4'b0000, 3, 0, 4'b1000, 4'b0000, 1);
        add(4'b1001, 0, 4'b0000, 3, 0, 4'b0000, 4'b0000, 0);
        add(4'b1001, 0, 4'b0001, 0, 1, 4'b0000, 4'b0000, 1);
        add(4'b0000, 1, 4'b0000, 0, 0, 4'b0001, 4'b0000, 1);
        add(4'b0100, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        // Timeout: mem_req is high for 4 cycles, then timeout pulses.
        add(4'b0100, 0, 4'b0100, 2, 1, 4'b0000, 4'b0000, 1);
        add(4'b0100, 0, 4'b0100, 2, 1, 4'b0000, 4'b0000, 1);
        add(4'b0100, 0, 4'b0100, 2, 1, 4'b0000, 4'b0000, 1);
        add(4'b0100, 0, 4'b0100, 2, 1, 4'b0000, 4'b0000, 1);
        add(4'b0100, 0, 4'b0000, 2, 0, 4'b0000, 4'b0100, 1);
        add(4'b0000, 0, 4'b0000, 2, 0, 4'b0000, 4'b0000, 0);
        // Ack on the timeout cycle: done wins and timeout does not pulse.
        add(4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000, 1);
        add(4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000, 1);
        add(4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000, 1);
        add(4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000, 1);
        add(4'b0010, 1, 4'b0000, 1, 0, 4'b0010, 4'b0000, 1);
        add(4'b0000, 0, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        // Enter BUSY on master 1 for the mid-transaction reset below.
        add(4'b0010, 0, 4'b0010, 1, 1, 4'b0000, 4'b0000, 1);

        // Reset held while every master requests.
        reset_n        = 1'b0;
        bus_if.req     = 4'b1111;
        bus_if.mem_ack = 1'b0;
        #1;
        check("rst_grant", bus_if.grant, 4'b0000);
        check("rst_select", {2'b00, bus_if.select}, 4'b0000);
        check("rst_mem_req", {3'b000, bus_if.mem_req}, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_grant", bus_if.grant, 4'b0000);
        check("rst_hold_busy", {3'b000, bus_if.busy}, 4'b0000);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            bus_if.req     = vecs[i].req;
            bus_if.mem_ack = vecs[i].ack;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_grant", i), bus_if.grant, vecs[i].grant);
            check($sformatf("v%0d_select", i), {2'b00, bus_if.select}, {2'b00, vecs[i].sel});
            check($sformatf("v%0d_mem_req", i), {3'b000, bus_if.mem_req}, {3'b000, vecs[i].mreq});
            check($sformatf("v%0d_done", i), bus_if.done, vecs[i].done);
            check($sformatf("v%0d_timeout", i), bus_if.timeout, vecs[i].tout);
            check($sformatf("v%0d_busy", i), {3'b000, bus_if.busy}, {3'b000, vecs[i].busy});
        end

        // Reset mid-BUSY: outputs must drop before any clock edge.
        #2;
        reset_n        = 1'b0;
        bus_if.mem_ack = 1'b1;
        #1;
        check("midrst_grant", bus_if.grant, 4'b0000);
        check("midrst_mem_req", {3'b000, bus_if.mem_req}, 4'b0000);
        check("midrst_busy", {3'b000, bus_if.busy}, 4'b0000);
        @(posedge clk);
        #1;
        check("midrst_done", bus_if.done, 4'b0000);
        check("midrst_timeout", bus_if.timeout, 4'b0000);
        reset_n        = 1'b1;
        bus_if.req     = 4'b0000;
        bus_if.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_done", bus_if.done, 4'b0000);
        check("postrst_grant", bus_if.grant, 4'b0000);
        check("postrst_select", {2'b00, bus_if.select}, 4'b0000);

        // After reset ptr is back to 0, so master 0 wins over master 2.
        bus_if.req = 4'b0101;
        @(posedge clk);
        #1;
        check("postrst_first_grant", bus_if.grant, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter4.md
# bus_arbiter4

Four-master round-robin bus arbiter sitting directly upstream of the four-input address/data bus mux. It takes up to four request lines, grants exactly one master at a time, and drives the mux's 2-bit `select` so the granted master's address and data reach memory. It also runs the single-beat request/acknowledge handshake toward memory, with a watchdog that ends any transaction memory never acknowledges.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 16: BUSY cycles allowed without `mem_ack` before forced release.
  - Legal range 0–255.
  - 0 disables the timeout.

Ports:
- `clk`  input  1  — system clock; all state updates on the rising edge.
- `reset_n`  input  1  — reset, asynchronous and active-low.
- `req`  input  4  — level request from masters 0–3; a master holds its bit high until its `done` or `timeout` pulse.
- `mem_ack`  input  1  — memory completion strobe; sampled only in BUSY.
- `grant`  output  4  — one-hot grant; all zero when no master owns the bus.
- `select`  output  2  — index of the granted master; drives the bus mux `select` input.
- `mem_req`  output  1  — bus transaction valid toward memory.
- `done`  output  4  — one-cycle pulse to the master whose transaction was acknowledged.
- `timeout`  output  4  — one-cycle pulse to the master whose transaction timed out.
- `busy`  output  1  — high in BUSY and RELEASE.

## Operation

- State machine: IDLE, BUSY, RELEASE; state register encoded in 2 bits.
- Round-robin pointer `ptr` (2 bits) names the highest-priority master.
  - Search order: `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- IDLE:
  - If `req != 0`, on the edge: `select` gets the first requesting index in search order, `grant` gets the one-hot of that index, watchdog counter clears to 0, and the state moves to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `mem_req` = 1.
  - If `mem_ack` = 1 on the edge: `done[select]` pulses next cycle, `ptr` gets `select+1` mod 4, state moves to RELEASE.
  - Else, if `TIMEOUT_CYCLES != 0` and counter == `TIMEOUT_CYCLES-1`: `timeout[select]` pulses next cycle, `ptr` advances the same way, state moves to RELEASE.
  - Else the counter increments.
  - If `mem_ack` and the timeout condition coincide, `mem_ack` wins: `done` pulses, `timeout` does not.
- RELEASE:
  - `grant` = 0 and `mem_req` = 0 for exactly one cycle, then IDLE.
  - This dead cycle keeps back-to-back grants separated.
- `select` holds its last value through IDLE and RELEASE so the downstream mux output never glitches to an unrelated master.
- A `req` bit deasserted during BUSY does not abort the transaction; it completes on ack or timeout.
- `mem_ack` in IDLE or RELEASE is ignored and produces no pulses.
- Requests arriving in BUSY or RELEASE are evaluated in IDLE against the updated `ptr`.
- Counter is 8 bits and saturates at 255; it never wraps.

## Timing

- Reset (async assert, sync to `clk` on release) clears all of the following:
  - state = IDLE
  - `ptr` = 0, `select` = 0
  - `grant` = 0, `mem_req` = 0
  - `done` = 0, `timeout` = 0, `busy` = 0
  - counter = 0
- Reset mid-transaction drops `grant` and `mem_req` immediately, with no `done` or `timeout` pulse.
- `grant`, `select`, `done`, `timeout` and state are registered.
- `mem_req` and `busy` are decoded from registered state, so they are glitch-free and have no combinational path from inputs.
- Request-to-grant latency: `req` high before edge N gives `grant`, `select` and `mem_req` valid after edge N.
- Ack-to-done latency: `mem_ack` sampled at edge M gives `done` high for the cycle after edge M, `mem_req` low after edge M, and IDLE after edge M+1.
- Minimum grant-to-grant period: 3 cycles (BUSY 1, RELEASE 1, IDLE 1).
- Timeout: with no ack, `mem_req` stays high for exactly `TIMEOUT_CYCLES` cycles.

## Test plan

- Reset: hold `reset_n` = 0 with `req` = 4'b1111.
  - Required: `grant` = 0, `select` = 0, `mem_req` = 0.
  - After release, first grant is `grant` = 4'b0001, `select` = 0.
- Round-robin fairness: `req` = 4'b1111 held, `mem_ack` pulsed one cycle after each `mem_req` rise.
  - Required: grant sequence 0,1,2,3,0 with `select` 0,1,2,3,0.
  - Each `done` bit pulses once, in that order.
- Pointer skip: after master 1 is served, set `req` = 4'b1001.
  - Required: master 3 is granted before master 0.
- Timeout: `TIMEOUT_CYCLES` = 4, `req` = 4'b0100, `mem_ack` never asserted.
  - Required: `mem_req` high for 4 cycles, `timeout` = 4'b0100 for one cycle, no `done`, then RELEASE and IDLE.
- Simultaneous and spurious ack:
  - `mem_ack` arriving on the timeout cycle gives a `done` pulse and no `timeout` pulse.
  - `mem_ack` in IDLE produces no pulses and no state change.
- Reset mid-BUSY: assert `reset_n` = 0 asynchronously while `grant` = 4'b0010.
  - Required: `grant` and `mem_req` go to 0 without waiting for a clock edge, and no `done` pulse follows.
